// File: rtl/riscv_register_writeback_pkg.sv
// Shared configuration and types for the register writeback stage.
// Holds the register-file geometry and the request-source selector.
package riscv_register_writeback_pkg;

    localparam int unsigned CFG_XLEN   = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_LD,
        SRC_ALU
    } wb_src_e;

    // x0 is hardwired to zero, so writes to it are dropped.
    function automatic logic writes_reg(input logic [REG_ADDR_W-1:0] rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/riscv_wb_fifo.sv
// Two-entry synchronous FIFO for {rd,data} writeback entries.
// Uses wrapping 1-bit pointers and an occupancy count; clr empties it.
module riscv_wb_fifo
    import riscv_register_writeback_pkg::*;
#(
    parameter int unsigned WIDTH = REG_ADDR_W + CFG_XLEN,
    parameter int unsigned DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == 2'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/riscv_register_writeback.sv
// Writeback stage: arbitrates load/ALU results into a small FIFO, drains it to
// the register-file write port, and tracks pending writes for fetch hazards.
module riscv_register_writeback
    import riscv_register_writeback_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned XLEN       = CFG_XLEN
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_clr,
    input  logic                  i_issue_vld,
    input  logic [REG_ADDR_W-1:0] i_issue_rd,
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    output logic                  o_hazard,
    input  logic                  i_alu_vld,
    input  logic [REG_ADDR_W-1:0] i_alu_rd,
    input  logic [XLEN-1:0]       i_alu_data,
    output logic                  o_alu_rdy,
    input  logic                  i_ld_vld,
    input  logic [REG_ADDR_W-1:0] i_ld_rd,
    input  logic [XLEN-1:0]       i_ld_data,
    output logic                  o_ld_rdy,
    output logic                  o_rf_we,
    output logic [REG_ADDR_W-1:0] o_rf_waddr,
    output logic [XLEN-1:0]       o_rf_wdata
);

    localparam int unsigned ENTRY_W = REG_ADDR_W + XLEN;

    wb_src_e               src;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [ENTRY_W-1:0]    push_entry;
    logic [ENTRY_W-1:0]    head;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [XLEN-1:0]       head_data;
    logic [NUM_REGS-1:0]   sb;
    logic [NUM_REGS-1:0]   sb_nxt;

    assign o_ld_rdy  = !full && !i_clr;
    assign o_alu_rdy = !full && !i_clr && !i_ld_vld;

    always_comb begin
        src        = SRC_NONE;
        push_entry = '0;
        if (i_ld_vld && o_ld_rdy) begin
            src = SRC_LD;
        end else if (i_alu_vld && o_alu_rdy) begin
            src = SRC_ALU;
        end
        unique case (src)
            SRC_LD:  push_entry = {i_ld_rd, i_ld_data};
            SRC_ALU: push_entry = {i_alu_rd, i_alu_data};
            default: push_entry = '0;
        endcase
    end

    assign push = (src != SRC_NONE);
    assign pop  = !empty && !i_clr;

    riscv_wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .clr    (i_clr),
        .push   (push),
        .pop    (pop),
        .wdata  (push_entry),
        .rdata  (head),
        .full   (full),
        .empty  (empty)
    );

    assign head_rd   = head[ENTRY_W-1:XLEN];
    assign head_data = head[XLEN-1:0];

    // Clear before set so a same-edge issue of the popped rd keeps the bit.
    always_comb begin
        sb_nxt = sb;
        if (pop) sb_nxt[head_rd] = 1'b0;
        if (i_issue_vld) sb_nxt[i_issue_rd] = 1'b1;
        sb_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sb <= '0;
        end else if (i_clr) begin
            sb <= '0;
        end else begin
            sb <= sb_nxt;
        end
    end

    assign o_hazard = sb[i_rs1] | sb[i_rs2];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_rf_we    <= 1'b0;
            o_rf_waddr <= '0;
            o_rf_wdata <= '0;
        end else if (i_clr) begin
            o_rf_we <= 1'b0;
        end else if (pop) begin
            o_rf_we <= writes_reg(head_rd);
            if (writes_reg(head_rd)) begin
                o_rf_waddr <= head_rd;
                o_rf_wdata <= head_data;
            end
        end else begin
            o_rf_we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_register_writeback.sv
// Directed bench for riscv_register_writeback: vector tables for the
// combinational ready/hazard paths plus hand-written multi-cycle sequences.
module tb_riscv_register_writeback;

    logic        clk;
    logic        rstn;
    logic        clr;
    logic        issue_vld;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        hazard;
    logic        alu_vld;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_rdy;
    logic        ld_vld;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_rdy;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    riscv_register_writeback #(
        .FIFO_DEPTH (2),
        .XLEN       (32)
    ) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_clr       (clr),
        .i_issue_vld (issue_vld),
        .i_issue_rd  (issue_rd),
        .i_rs1       (rs1),
        .i_rs2       (rs2),
        .o_hazard    (hazard),
        .i_alu_vld   (alu_vld),
        .i_alu_rd    (alu_rd),
        .i_alu_data  (alu_data),
        .o_alu_rdy   (alu_rdy),
        .i_ld_vld    (ld_vld),
        .i_ld_rd     (ld_rd),
        .i_ld_data   (ld_data),
        .o_ld_rdy    (ld_rdy),
        .o_rf_we     (rf_we),
        .o_rf_waddr  (rf_waddr),
        .o_rf_wdata  (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic ld;
        logic alu;
        logic clr;
        logic exp_ld_rdy;
        logic exp_alu_rdy;
    } rdy_vec_t;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       exp_hz;
    } hz_vec_t;

    rdy_vec_t rdy_tbl[8];
    hz_vec_t  hz_tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input string name, input logic [4:0] a, input logic [31:0] d);
        check({name, " we"}, 32'(rf_we), 32'd1);
        check({name, " waddr"}, 32'(rf_waddr), 32'(a));
        check({name, " wdata"}, rf_wdata, d);
    endtask

    initial begin
        rdy_tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        rdy_tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        rdy_tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        rdy_tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        rdy_tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        rdy_tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        rdy_tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        rdy_tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        // Pending writes after setup: x5, x9, x31 (x0 issue must not stick).
        hz_tbl[0] = '{5'd5,  5'd0,  1'b1};
        hz_tbl[1] = '{5'd0,  5'd0,  1'b0};
        hz_tbl[2] = '{5'd1,  5'd2,  1'b0};
        hz_tbl[3] = '{5'd2,  5'd31, 1'b1};
        hz_tbl[4] = '{5'd9,  5'd9,  1'b1};
        hz_tbl[5] = '{5'd8,  5'd30, 1'b0};
        hz_tbl[6] = '{5'd0,  5'd9,  1'b1};

        rstn = 1'b0; clr = 1'b0;
        issue_vld = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
        alu_vld = 1'b0; alu_rd = '0; alu_data = '0;
        ld_vld = 1'b0; ld_rd = '0; ld_data = '0;
        #1;

        check("reset we", 32'(rf_we), 32'd0);
        check("reset waddr", 32'(rf_waddr), 32'd0);
        check("reset wdata", rf_wdata, 32'd0);
        check("reset hazard", 32'(hazard), 32'd0);

        for (int i = 0; i < 8; i++) begin
            ld_vld = rdy_tbl[i].ld; alu_vld = rdy_tbl[i].alu; clr = rdy_tbl[i].clr;
            #1;
            check($sformatf("rdy_tbl[%0d] ld_rdy", i), 32'(ld_rdy), 32'(rdy_tbl[i].exp_ld_rdy));
            check($sformatf("rdy_tbl[%0d] alu_rdy", i), 32'(alu_rdy), 32'(rdy_tbl[i].exp_alu_rdy));
        end
        ld_vld = 1'b0; alu_vld = 1'b0; clr = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        tick();

        issue_vld = 1'b1;
        issue_rd = 5'd5;  tick();
        issue_rd = 5'd9;  tick();
        issue_rd = 5'd0;  tick();
        issue_rd = 5'd31; tick();
        issue_vld = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rs1 = hz_tbl[i].rs1; rs2 = hz_tbl[i].rs2;
            #1;
            check($sformatf("hz_tbl[%0d]", i), 32'(hazard), 32'(hz_tbl[i].exp_hz));
        end
        clr = 1'b1; tick(); clr = 1'b0;
        rs1 = 5'd5; rs2 = 5'd31;
        check("clr sb", 32'(hazard), 32'd0);

        // Single ALU write with hazard release at the write cycle
        issue_vld = 1'b1; issue_rd = 5'd5; tick(); issue_vld = 1'b0;
        rs2 = 5'd0;
        check("alu1 hazard pre", 32'(hazard), 32'd1);
        alu_vld = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1 check("alu1 rdy", 32'(alu_rdy), 32'd1);
        tick(); alu_vld = 1'b0;
        check("alu1 we early", 32'(rf_we), 32'd0);
        check("alu1 hazard held", 32'(hazard), 32'd1);
        tick();
        expect_write("alu1", 5'd5, 32'hDEADBEEF);
        check("alu1 hazard rel", 32'(hazard), 32'd0);
        tick();
        check("alu1 we drop", 32'(rf_we), 32'd0);

        // Simultaneous load and ALU: load first, ALU stalls
        ld_vld = 1'b1; ld_rd = 5'd3; ld_data = 32'd1;
        alu_vld = 1'b1; alu_rd = 5'd4; alu_data = 32'd2;
        #1;
        check("sim ld_rdy", 32'(ld_rdy), 32'd1);
        check("sim alu_rdy", 32'(alu_rdy), 32'd0);
        tick(); ld_vld = 1'b0;
        #1 check("sim alu_rdy2", 32'(alu_rdy), 32'd1);
        tick(); alu_vld = 1'b0;
        expect_write("sim w0", 5'd3, 32'd1);
        tick();
        expect_write("sim w1", 5'd4, 32'd2);
        tick();
        check("sim idle", 32'(rf_we), 32'd0);

        // Back-to-back ALU stream: one write per cycle, order preserved
        alu_vld = 1'b1;
        for (int k = 0; k < 3; k++) begin
            alu_rd = 5'(10 + k); alu_data = 32'hA0 + 32'(k);
            #1 check($sformatf("b2b rdy %0d", k), 32'(alu_rdy), 32'd1);
            tick();
            if (k > 0) expect_write($sformatf("b2b w%0d", k - 1), 5'(9 + k), 32'hA0 + 32'(k - 1));
        end
        alu_vld = 1'b0;
        tick();
        expect_write("b2b w2", 5'd12, 32'hA2);
        tick();
        check("b2b idle", 32'(rf_we), 32'd0);

        // rd=0 request is accepted and dropped
        alu_vld = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
        #1 check("x0 rdy", 32'(alu_rdy), 32'd1);
        tick(); alu_vld = 1'b0;
        tick();
        check("x0 we", 32'(rf_we), 32'd0);
        rs1 = 5'd0; rs2 = 5'd0;
        #1 check("x0 hazard", 32'(hazard), 32'd0);

        // Set/clear collision on x7
        rs2 = 5'd7;
        issue_vld = 1'b1; issue_rd = 5'd7; tick(); issue_vld = 1'b0;
        alu_vld = 1'b1; alu_rd = 5'd7; alu_data = 32'h77; tick(); alu_vld = 1'b0;
        issue_vld = 1'b1; issue_rd = 5'd7; tick(); issue_vld = 1'b0;
        expect_write("coll", 5'd7, 32'h77);
        check("coll hazard", 32'(hazard), 32'd1);
        tick();
        check("coll hazard hold", 32'(hazard), 32'd1);
        alu_vld = 1'b1; alu_data = 32'h78; tick(); alu_vld = 1'b0;
        tick();
        check("coll hazard clear", 32'(hazard), 32'd0);

        // Flush with an entry buffered and x9 pending
        issue_vld = 1'b1; issue_rd = 5'd9; tick(); issue_vld = 1'b0;
        alu_vld = 1'b1; alu_rd = 5'd9; alu_data = 32'h99; tick();
        clr = 1'b1; alu_rd = 5'd13; issue_vld = 1'b1; issue_rd = 5'd14;
        #1;
        check("flush alu_rdy", 32'(alu_rdy), 32'd0);
        check("flush ld_rdy", 32'(ld_rdy), 32'd0);
        tick();
        clr = 1'b0; alu_vld = 1'b0; issue_vld = 1'b0;
        rs1 = 5'd9; rs2 = 5'd14;
        #1;
        check("flush we", 32'(rf_we), 32'd0);
        check("flush hazard", 32'(hazard), 32'd0);
        tick();
        check("flush empty", 32'(rf_we), 32'd0);

        // Async reset mid-stream
        rs1 = 5'd20; rs2 = 5'd0;
        issue_vld = 1'b1; issue_rd = 5'd20; tick(); issue_vld = 1'b0;
        alu_vld = 1'b1; alu_rd = 5'd20; alu_data = 32'h1234; tick();
        alu_rd = 5'd21; alu_data = 32'h21; tick();
        expect_write("rst pre", 5'd20, 32'h1234);
        #2 rstn = 1'b0;
        #1;
        check("rst we", 32'(rf_we), 32'd0);
        check("rst waddr", 32'(rf_waddr), 32'd0);
        check("rst wdata", rf_wdata, 32'd0);
        check("rst hazard", 32'(hazard), 32'd0);
        check("rst ld_rdy", 32'(ld_rdy), 32'd1);
        check("rst alu_rdy", 32'(alu_rdy), 32'd1);
        alu_vld = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        tick();
        check("rst discard", 32'(rf_we), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
